bram_fifo_ctrl: RTL and testbench

BRAM_FIFO_CTRL -- requirements
Module: bram_fifo_ctrl

---
 rtl/bram_fifo_ctrl.sv | 119 +++++++++++
 tb/tb_bram_fifo_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/bram_fifo_ctrl.sv
// FIFO controller in front of an external 1-cycle-latency BRAM; the BRAM read
// register doubles as the output stage, so rd_data_o comes straight from it.
module bram_fifo_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       wr_valid_i,
  output logic                       wr_ready_o,
  input  logic [DATA_WIDTH-1:0]      wr_data_i,
  output logic                       rd_valid_o,
  input  logic                       rd_ready_i,
  output logic [DATA_WIDTH-1:0]      rd_data_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       ram_wr_en_o,
  output logic [$clog2(DEPTH)-1:0]   ram_wr_addr_o,
  output logic [DATA_WIDTH-1:0]      ram_wr_data_o,
  output logic                       ram_rd_en_o,
  output logic [$clog2(DEPTH)-1:0]   ram_rd_addr_o,
  input  logic [DATA_WIDTH-1:0]      ram_rd_data_i
);

  localparam int unsigned AddrWidth = $clog2(DEPTH);
  localparam int unsigned CntWidth  = AddrWidth + 1;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_VALID = 1'b1
  } out_state_e;

  out_state_e            state_q, state_d;
  logic [AddrWidth-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AddrWidth-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntWidth-1:0]   mem_count_q, mem_count_d;
  logic                  accept;
  logic                  fetch;

  // Handshakes and BRAM port drive; mem_count only covers words written in
  // earlier cycles, so a same-cycle write can never be fetched.
  always_comb begin
    wr_ready_o    = !rst_i && (mem_count_q != CntWidth'(DEPTH));
    accept        = wr_valid_i && wr_ready_o && !flush_i;
    fetch         = (mem_count_q != '0) && (!rd_valid_o || rd_ready_i) && !flush_i;
    ram_wr_en_o   = accept;
    ram_wr_addr_o = wr_ptr_q;
    ram_wr_data_o = wr_data_i;
    ram_rd_en_o   = fetch;
    ram_rd_addr_o = rd_ptr_q;
    rd_data_o     = ram_rd_data_i;
    level_o       = mem_count_q + CntWidth'(rd_valid_o);
  end

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    mem_count_d = mem_count_q;
    if (flush_i) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      mem_count_d = '0;
    end else begin
      if (accept) wr_ptr_d = wr_ptr_q + AddrWidth'(1);
      if (fetch)  rd_ptr_d = rd_ptr_q + AddrWidth'(1);
      case ({accept, fetch})
        2'b10:   mem_count_d = mem_count_q + CntWidth'(1);
        2'b01:   mem_count_d = mem_count_q - CntWidth'(1);
        default: mem_count_d = mem_count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_count_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_count_q <= mem_count_d;
    end
  end

  // Output-stage FSM: state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= OUT_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Output-stage FSM: next state.
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = OUT_EMPTY;
    end else begin
      case (state_q)
        OUT_EMPTY: if (fetch) state_d = OUT_VALID;
        OUT_VALID: if (!fetch && rd_ready_i) state_d = OUT_EMPTY;
        default:   state_d = OUT_EMPTY;
      endcase
    end
  end

  // Output-stage FSM: outputs.
  always_comb begin
    rd_valid_o = 1'b0;
    case (state_q)
      OUT_VALID: rd_valid_o = 1'b1;
      default:   rd_valid_o = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Bench for bram_fifo_ctrl: behavioural BRAM, expected-word queue checked by
// an independent output monitor, plus directed cycle checks.
module tb_bram_fifo_ctrl;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = $clog2(DEPTH);

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          flush_i;
  logic          wr_valid_i;
  logic          wr_ready_o;
  logic [DW-1:0] wr_data_i;
  logic          rd_valid_o;
  logic          rd_ready_i;
  logic [DW-1:0] rd_data_o;
  logic [AW:0]   level_o;
  logic          ram_wr_en_o;
  logic [AW-1:0] ram_wr_addr_o;
  logic [DW-1:0] ram_wr_data_o;
  logic          ram_rd_en_o;
  logic [AW-1:0] ram_rd_addr_o;
  logic [DW-1:0] ram_rd_data_i;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] exp_q [$];
  int checks = 0;
  int passes = 0;

  bram_fifo_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_data_i(wr_data_i),
    .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i), .rd_data_o(rd_data_o),
    .level_o(level_o),
    .ram_wr_en_o(ram_wr_en_o), .ram_wr_addr_o(ram_wr_addr_o), .ram_wr_data_o(ram_wr_data_o),
    .ram_rd_en_o(ram_rd_en_o), .ram_rd_addr_o(ram_rd_addr_o), .ram_rd_data_i(ram_rd_data_i)
  );

  always #5 clk_i = ~clk_i;

  // BRAM: registered read returning old data on same-address collision.
  always @(posedge clk_i) begin
    if (ram_wr_en_o) mem[ram_wr_addr_o] <= ram_wr_data_o;
    if (ram_rd_en_o) ram_rd_data_i <= mem[ram_rd_addr_o];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: every handshake on the read side must match the next expected word.
  always @(negedge clk_i) begin
    if (rd_valid_o && rd_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL rd_unexpected: got 0x%0h, expected no word (t=%0t)", rd_data_o, $time);
      end else begin
        chk("rd_data", 32'(rd_data_o), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Drain with rd_ready high; bounded wait for the FIFO to empty.
  task automatic drain(input string name);
    bit done = 1'b0;
    wr_valid_i = 1'b0;
    rd_ready_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (level_o == '0) begin
        done = 1'b1;
        break;
      end
      step();
    end
    chk({name, "_drained"}, 32'(done), 32'd1);
    chk({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    step();
  endtask

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; wr_valid_i = 1'b1; wr_data_i = 8'hEE; rd_ready_i = 1'b0;

    // Reset state, with a write request pending.
    @(negedge clk_i);
    chk("rst_wr_ready", 32'(wr_ready_o), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid_o), 32'd0);
    chk("rst_level", 32'(level_o), 32'd0);
    chk("rst_ram_wr_en", 32'(ram_wr_en_o), 32'd0);
    chk("rst_ram_rd_en", 32'(ram_rd_en_o), 32'd0);
    step();
    rst_i = 1'b0; wr_valid_i = 1'b0;
    @(negedge clk_i);
    chk("rel_wr_ready", 32'(wr_ready_o), 32'd1);
    chk("rel_level", 32'(level_o), 32'd0);
    step();

    // Single word latency.
    wr_valid_i = 1'b1; wr_data_i = 8'hA5; rd_ready_i = 1'b1; exp_q.push_back(8'hA5);
    @(negedge clk_i);
    chk("lat_c0_wr_en", 32'(ram_wr_en_o), 32'd1);
    chk("lat_c0_wr_addr", 32'(ram_wr_addr_o), 32'd0);
    chk("lat_c0_wr_data", 32'(ram_wr_data_o), 32'hA5);
    chk("lat_c0_rd_en", 32'(ram_rd_en_o), 32'd0);
    step();
    wr_valid_i = 1'b0;
    @(negedge clk_i);
    chk("lat_c1_rd_en", 32'(ram_rd_en_o), 32'd1);
    chk("lat_c1_rd_addr", 32'(ram_rd_addr_o), 32'd0);
    chk("lat_c1_rd_valid", 32'(rd_valid_o), 32'd0);
    step();
    @(negedge clk_i);
    chk("lat_c2_rd_valid", 32'(rd_valid_o), 32'd1);
    chk("lat_c2_rd_data", 32'(rd_data_o), 32'hA5);
    step();

    // Fill with reader stalled: five words fit (4 in memory + output stage).
    rd_ready_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      wr_valid_i = 1'b1; wr_data_i = 8'(k + 1);
      if (k < 5) exp_q.push_back(8'(k + 1));
      @(negedge clk_i);
      if (k == 5) begin
        chk("full_wr_ready", 32'(wr_ready_o), 32'd0);
        chk("full_level", 32'(level_o), 32'd5);
        chk("full_ram_wr_en", 32'(ram_wr_en_o), 32'd0);
      end
      step();
    end
    drain("full");

    // Output held stable under backpressure while writes keep arriving.
    rd_ready_i = 1'b0; wr_valid_i = 1'b1; wr_data_i = 8'h10; exp_q.push_back(8'h10);
    step();
    wr_valid_i = 1'b0;
    step();
    for (int k = 0; k < 5; k++) begin
      wr_valid_i = (k < 4); wr_data_i = 8'(8'h11 + k);
      if (k < 4) exp_q.push_back(8'(8'h11 + k));
      @(negedge clk_i);
      chk("hold_rd_valid", 32'(rd_valid_o), 32'd1);
      chk("hold_rd_data", 32'(rd_data_o), 32'h10);
      chk("hold_ram_rd_en", 32'(ram_rd_en_o), 32'd0);
      step();
    end
    drain("hold");

    // Streaming: 12 words, one output per cycle after two-cycle fill.
    rd_ready_i = 1'b1;
    for (int c = 0; c < 14; c++) begin
      wr_valid_i = (c < 12); wr_data_i = 8'(8'h20 + c);
      if (c < 12) exp_q.push_back(8'(8'h20 + c));
      @(negedge clk_i);
      if (c >= 2) chk("stream_rd_valid", 32'(rd_valid_o), 32'd1);
      step();
    end
    wr_valid_i = 1'b0;
    @(negedge clk_i);
    chk("stream_end_level", 32'(level_o), 32'd0);
    chk("stream_end_queue", 32'(exp_q.size()), 32'd0);
    step();

    // Flush at level 3 with a simultaneous write.
    rd_ready_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      wr_valid_i = 1'b1; wr_data_i = 8'(8'h30 + c);
      step();
    end
    flush_i = 1'b1; wr_valid_i = 1'b1; wr_data_i = 8'h99;
    @(negedge clk_i);
    chk("flush_pre_level", 32'(level_o), 32'd3);
    chk("flush_ram_wr_en", 32'(ram_wr_en_o), 32'd0);
    chk("flush_ram_rd_en", 32'(ram_rd_en_o), 32'd0);
    step();
    flush_i = 1'b0; wr_valid_i = 1'b0;
    @(negedge clk_i);
    chk("flush_post_level", 32'(level_o), 32'd0);
    chk("flush_post_rd_valid", 32'(rd_valid_o), 32'd0);
    chk("flush_post_wr_ready", 32'(wr_ready_o), 32'd1);
    rd_ready_i = 1'b1;
    repeat (3) step();

    // Asynchronous reset pulse mid-burst, between clock edges.
    rd_ready_i = 1'b0;
    wr_valid_i = 1'b1; wr_data_i = 8'h40; step();
    wr_data_i = 8'h41; step();
    wr_data_i = 8'h42;
    #1 rst_i = 1'b1;
    #1;
    chk("arst_rd_valid", 32'(rd_valid_o), 32'd0);
    chk("arst_level", 32'(level_o), 32'd0);
    chk("arst_wr_ready", 32'(wr_ready_o), 32'd0);
    chk("arst_ram_wr_en", 32'(ram_wr_en_o), 32'd0);
    chk("arst_ram_rd_en", 32'(ram_rd_en_o), 32'd0);
    wr_valid_i = 1'b0;
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    chk("arst_rel_wr_ready", 32'(wr_ready_o), 32'd1);
    chk("arst_rel_level", 32'(level_o), 32'd0);
    step();
    rd_ready_i = 1'b1;
    repeat (3) step();
    wr_valid_i = 1'b1; wr_data_i = 8'h5A; exp_q.push_back(8'h5A);
    @(negedge clk_i);
    chk("arst_after_wr_addr", 32'(ram_wr_addr_o), 32'd0);
    step();
    drain("arst");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
